// File: rtl/ex_mem_stage_if.sv
// EX->MEM payload bundle: EX-side instruction fields and the registered MEM-side copy.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8
);
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_wd;
    logic              ex_wreg;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_whilo;
    logic [DATA_W-1:0] ex_hi;
    logic [DATA_W-1:0] ex_lo;
    logic [OP_W-1:0]   ex_aluop;
    logic [DATA_W-1:0] ex_mem_addr;
    logic [DATA_W-1:0] ex_reg2;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_wd;
    logic              mem_wreg;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_whilo;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic [OP_W-1:0]   mem_aluop;
    logic [DATA_W-1:0] mem_mem_addr;
    logic [DATA_W-1:0] mem_reg2;

    modport master (
        output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
               ex_aluop, ex_mem_addr, ex_reg2,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               mem_aluop, mem_mem_addr, mem_reg2
    );

    modport slave (
        input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
               ex_aluop, ex_mem_addr, ex_reg2,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               mem_aluop, mem_mem_addr, mem_reg2
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with flush, bubble/hold stalls and multi-cycle accumulator return.
// Optional saturating stall/bubble counters are built when EX_MEM_PERF_EN is defined.
module ex_mem_stage #(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 5,
    parameter int              OP_W    = 8,
    parameter int              CNT_W   = 2,
    parameter int              STALL_W = 6,
    parameter int              STAGE   = 3,
    parameter logic [OP_W-1:0] NOP_OP  = 8'h00,
    parameter int              PERF_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [CNT_W-1:0]    cnt_i,
    input  logic [2*DATA_W-1:0] hilo_temp_i,
    input  logic                perf_clr,
    ex_mem_stage_if.slave       bus,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [PERF_W-1:0]   stall_cycles,
    output logic [PERF_W-1:0]   bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic [OP_W-1:0]   aluop;
        logic [DATA_W-1:0] mem_addr;
        logic [DATA_W-1:0] reg2;
    } slot_t;

    function automatic slot_t empty_slot();
        slot_t s;
        s       = '0;
        s.aluop = NOP_OP;
        return s;
    endfunction

    slot_t                slot_q, slot_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*DATA_W-1:0]  hilo_q, hilo_d;

    logic advance, bubble, hold;

    // Non-monotone stall (own bit clear, downstream set) falls into advance.
    assign advance = ~stall[STAGE];
    assign bubble  = stall[STAGE] & ~stall[STAGE+1];
    assign hold    = stall[STAGE] & stall[STAGE+1];

    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        hilo_d = hilo_q;
        if (flush) begin
            slot_d = empty_slot();
            cnt_d  = '0;
            hilo_d = '0;
        end else if (advance) begin
            slot_d.valid    = bus.ex_valid;
            slot_d.wd       = bus.ex_wd;
            slot_d.wreg     = bus.ex_wreg & bus.ex_valid;
            slot_d.wdata    = bus.ex_wdata;
            slot_d.whilo    = bus.ex_whilo & bus.ex_valid;
            slot_d.hi       = bus.ex_hi;
            slot_d.lo       = bus.ex_lo;
            slot_d.aluop    = bus.ex_valid ? bus.ex_aluop : NOP_OP;
            slot_d.mem_addr = bus.ex_mem_addr;
            slot_d.reg2     = bus.ex_reg2;
            cnt_d           = '0;
            hilo_d          = '0;
        end else begin
            // Stalled: EX keeps iterating, so its accumulator is looped back.
            if (bubble) begin
                slot_d = empty_slot();
            end
            cnt_d  = cnt_i;
            hilo_d = hilo_temp_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= empty_slot();
            cnt_q  <= '0;
            hilo_q <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            hilo_q <= hilo_d;
        end
    end

    assign bus.mem_valid    = slot_q.valid;
    assign bus.mem_wd       = slot_q.wd;
    assign bus.mem_wreg     = slot_q.wreg;
    assign bus.mem_wdata    = slot_q.wdata;
    assign bus.mem_whilo    = slot_q.whilo;
    assign bus.mem_hi       = slot_q.hi;
    assign bus.mem_lo       = slot_q.lo;
    assign bus.mem_aluop    = slot_q.aluop;
    assign bus.mem_mem_addr = slot_q.mem_addr;
    assign bus.mem_reg2     = slot_q.reg2;
    assign cnt_o            = cnt_q;
    assign hilo_temp_o      = hilo_q;

    // Only bits STAGE and STAGE+1 of the stall vector matter here.
    logic unused_stall;
    assign unused_stall = ^stall;

`ifdef EX_MEM_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        bubble_cnt_d   = bubble_cnt_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
            bubble_cnt_d   = '0;
        end else if (!flush) begin
            if (bubble || hold) stall_cycles_d = sat_inc(stall_cycles_q);
            if (bubble)         bubble_cnt_d   = sat_inc(bubble_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_cnt   = bubble_cnt_q;
`else
    logic unused_perf;
    assign unused_perf  = perf_clr;
    assign stall_cycles = '0;
    assign bubble_cnt   = '0;
`endif

endmodule
